// File: rtl/acc_drv.sv
// Serial driver for a bit-serial accumulator: turns add/clear commands into
// MSB-first add frames (optionally trimmed of leading zeros) and clear strobes.
module acc_drv #(
  parameter int WIDTH = 33,
  parameter bit TRIM  = 1'b1
) (
  input  logic             clk,
  input  logic             Rst,
  input  logic             in_valid,
  input  logic             in_clr,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             add,
  output logic             rx,
  output logic             clear,
  output logic             busy,
  output logic [1:0]       o_dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

  // Handshake: a command transfers on a rising edge where in_valid && in_ready;
  // in_ready is high only in IDLE outside reset, so inputs are ignored elsewhere.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    CLR  = 2'd3
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_add, w_add_nxt;
  logic             r_clear, w_clear_nxt;
  logic [CW-1:0]    w_top;
  logic [CW-1:0]    w_align;
  logic             w_accept;

  // Index of the first bit to send: highest set bit when trimming, else the MSB.
  always_comb begin
    w_top = '0;
    if (TRIM) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (in_data[i]) w_top = CW'(i);
      end
    end else begin
      w_top = CW'(WIDTH - 1);
    end
  end

  assign w_align  = CW'(WIDTH - 1) - w_top;
  assign in_ready = (r_state == IDLE) && !Rst;
  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_add_nxt   = 1'b0;
    w_clear_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (in_clr) begin
            w_state_nxt = CLR;
            w_clear_nxt = 1'b1;
          end else begin
            // MSB-align the word so rx is always the top bit of the shifter.
            w_state_nxt = SEND;
            w_add_nxt   = 1'b1;
            w_shift_nxt = in_data << w_align;
            w_cnt_nxt   = w_top;
          end
        end
      end
      SEND: begin
        if (r_cnt == '0) begin
          w_state_nxt = GAP;
          w_shift_nxt = '0;
        end else begin
          w_add_nxt   = 1'b1;
          w_shift_nxt = r_shift << 1;
          w_cnt_nxt   = r_cnt - 1'b1;
        end
      end
      GAP:     w_state_nxt = IDLE;
      CLR:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_add   <= 1'b0;
      r_clear <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
      r_add   <= w_add_nxt;
      r_clear <= w_clear_nxt;
    end
  end

  // The shifter is zero outside SEND, so rx is low whenever add is low.
  assign rx          = r_shift[WIDTH-1];
  assign add         = r_add;
  assign clear       = r_clear;
  assign busy        = (r_state != IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: doc/acc_drv.md
ACC_DRV -- requirements
Module: acc_drv

Interface
REQ-001 Parameter WIDTH, default 33: command data width; equals the serial accumulator's shift-register width.
REQ-002 Parameter TRIM, default 1: 1 = suppress leading zero bits; 0 = always send WIDTH bits.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-005 in_valid  input  1  command present.
REQ-006 in_clr  input  1  command type: 1 = clear accumulator, 0 = add in_data.
REQ-007 in_data  input  WIDTH  unsigned addend; ignored when in_clr=1.
REQ-008 in_ready  output  1  block can accept a command this cycle.
REQ-009 add  output  1  serial frame enable to accumulator; high for exactly the data-bit cycles of one word.
REQ-010 rx  output  1  serial data bit, MSB first, valid while add=1.
REQ-011 clear  output  1  one-cycle accumulator clear strobe.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 States SHALL be IDLE, SEND, GAP, CLR; add, rx, clear SHALL be registered outputs.
REQ-014 in_ready SHALL equal (state==IDLE) and Rst deasserted; a command is accepted on a rising edge with in_valid && in_ready.
REQ-015 Accept with in_clr=1: IDLE->CLR; clear=1 for exactly the next cycle, add=0; then CLR->IDLE.
REQ-016 Accept with in_clr=0: capture in_data and length L; IDLE->SEND; add=1 and rx=in_data[L-1] from the next cycle.
REQ-017 L SHALL be WIDTH when TRIM=0; when TRIM=1, L = index of highest set bit + 1, minimum 1 (in_data=0 gives L=1, rx=0).
REQ-018 In SEND, each edge SHALL present the next lower bit on rx; after the bit at index 0 has been presented for one cycle, SEND->GAP.
REQ-019 add SHALL be high for exactly L consecutive cycles per word, with no gaps inside a word.
REQ-020 In GAP: add=0, rx=0, clear=0 for one cycle (accumulator commit cycle); then GAP->IDLE.
REQ-021 add and clear SHALL never be high in the same cycle; rx SHALL be 0 whenever add=0.
REQ-022 Per-word occupancy is L+2 cycles; with in_valid held high, add-low spacing between words is exactly 2 cycles.
REQ-023 Per-clear occupancy is 2 cycles.
REQ-024 in_valid, in_clr and in_data SHALL be ignored outside IDLE; captured data is unaffected by later input changes.
REQ-025 Bit counter width SHALL be ceil(log2(WIDTH+1)); no wrap-around is permitted.

Reset
REQ-026 Rst assertion SHALL immediately (asynchronously) force state=IDLE, add=0, rx=0, clear=0, busy=0, in_ready=0, shift register and counter=0.
REQ-027 Reset mid-SEND or mid-CLR SHALL abort with no further add or clear pulse; the first command after deassertion is handled normally.

Verification
REQ-028 Reset then idle -> add=0, rx=0, clear=0, busy=0; in_ready=1 from the first edge after Rst deasserts.
REQ-029 TRIM=1, in_data=0x5 -> add high 3 cycles, rx=1,0,1, one GAP cycle, in_ready high on the next cycle; in_data=0 -> add high 1 cycle, rx=0.
REQ-030 TRIM=1, in_data=0x1_FFFF_FFFF -> add high 33 cycles, rx all 1; TRIM=0, in_data=0x3 -> add high 33 cycles, rx = 31 zeros then 1,1.
REQ-031 in_clr=1 accepted -> clear=1 for exactly one cycle, add=0 throughout; in_ready low that cycle, high the next.
REQ-032 End-to-end with the serial accumulator: add 3, add 4 back-to-back (in_valid held) -> big=7; add 0xFFFFFFFF twice -> big=0x1_FFFF_FFFE; clear -> big=0.
REQ-033 Rst pulsed during the 2nd bit of a 20-bit word -> add drops immediately, no commit occurs, accumulator value unchanged; the next word sends correctly.
